// File: rtl/i2c_arb_pkg.sv
// Shared widths, FSM encoding and command record for the I2C master arbiter.
package i2c_arb_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TIMER_W = 17;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rw;
    } i2c_cmd_t;

    // Index of the set bit of a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Command/handshake bundle between the arbiter and the single I2C master controller.
interface i2c_master_arbiter_if;
    import i2c_arb_pkg::*;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rw;
    logic              m_enable;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_addr, m_wdata, m_rw, m_enable,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_addr, m_wdata, m_rw, m_enable,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_grant, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int LG_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LG_W-1:0] last_grant,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    localparam logic [LG_W:0] NREQ_W = (LG_W + 1)'(NREQ);

    logic [LG_W:0]   sum;
    logic [LG_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = {1'b0, last_grant} + (LG_W + 1)'(off);
            idx = (sum >= NREQ_W) ? LG_W'(sum - NREQ_W) : LG_W'(sum);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between NREQ requesters: round-robin grant, enable/ready
// handshake with start and busy timeouts, read data and status back to the winner.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = 1024,
    parameter int BUSY_TIMEOUT  = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]        req_rw,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             dbg_state,
    i2c_master_arbiter_if.master   m
);

    localparam int LG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TIMER_W-1:0] START_LIMIT = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BUSY_LIMIT  = TIMER_W'(BUSY_TIMEOUT - 1);

    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic [LG_W-1:0]    last_grant;
    logic [NREQ-1:0]    arb_winner;
    logic               arb_valid;
    i2c_cmd_t           sel_cmd;
    i2c_cmd_t           cmd_q;
    logic               enable_q;
    logic               err_q;
    logic [DATA_W-1:0]  rdata_q;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_winner[i]) begin
                sel_cmd.addr  = req_addr[ADDR_W*i +: ADDR_W];
                sel_cmd.wdata = req_wdata[DATA_W*i +: DATA_W];
                sel_cmd.rw    = req_rw[i];
            end
        end
    end

    assign timer_inc = (&timer) ? timer : timer + 1'b1;

    // Requester handshake: req is a level held until done; gnt is high from
    // latch to done; done/err/rdata are a single registered completion beat.
    // Master handshake: enable asks for a transfer, ready falling acknowledges
    // the start, ready rising ends it. The command stays frozen meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            cmd_q      <= '0;
            enable_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            timer      <= '0;
            last_grant <= LG_W'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (m.m_ready && arb_valid) begin
                        gnt   <= arb_winner;
                        cmd_q <= sel_cmd;
                        err_q <= 1'b0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A timeout on the limit cycle wins over a late ready edge.
                    if (timer == START_LIMIT) begin
                        enable_q <= 1'b0;
                        err_q    <= 1'b1;
                        state    <= ST_DONE;
                    end else if (!m.m_ready) begin
                        enable_q <= 1'b0;
                        timer    <= '0;
                        state    <= ST_BUSY;
                    end else begin
                        enable_q <= 1'b1;
                        timer    <= timer_inc;
                    end
                end
                ST_BUSY: begin
                    if (timer == BUSY_LIMIT) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else if (m.m_ready) begin
                        err_q <= 1'b0;
                        if (cmd_q.rw) rdata_q <= m.m_rdata;
                        state <= ST_DONE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_DONE: begin
                    done       <= gnt;
                    err        <= err_q;
                    rdata      <= rdata_q;
                    last_grant <= LG_W'(onehot_idx(8'(gnt)));
                    gnt        <= '0;
                    timer      <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m.m_addr   = cmd_q.addr;
    assign m.m_wdata  = cmd_q.wdata;
    assign m.m_rw     = cmd_q.rw;
    assign m.m_enable = enable_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed and randomized bench for i2c_master_arbiter with a behavioural master
// model and a round-robin reference kept as plain integers.
module tb_i2c_master_arbiter;
    import i2c_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int ST   = 300;
    localparam int BT   = 3000;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        req_rw;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic [7:0]             rdata;
    logic [1:0]             dbg_state;

    i2c_master_arbiter_if bus();

    i2c_master_arbiter #(.NREQ(NREQ), .START_TIMEOUT(ST), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .dbg_state(dbg_state), .m(bus)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural master: drops ready start_delay cycles after seeing enable,
    // raises it busy_delay cycles later with slave_rdata on its data output.
    int         start_delay = 5;
    int         busy_delay = 10;
    bit         stuck = 1'b0;
    bit         hold_low = 1'b0;
    logic [7:0] slave_rdata = 8'h00;
    int         m_phase = 0;
    int         m_cnt = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            bus.m_ready = 1'b1;
            bus.m_rdata = 8'h00;
        end else begin
            case (m_phase)
                0: begin
                    bus.m_ready = !hold_low;
                    if (bus.m_enable && !stuck) begin
                        m_cnt = 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt >= start_delay) begin
                        bus.m_ready = 1'b0;
                        fall_cyc = cyc;
                        m_cnt = 0;
                        m_phase = 2;
                    end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt >= busy_delay || done != '0) begin
                        bus.m_ready = 1'b1;
                        bus.m_rdata = slave_rdata;
                        rise_cyc = cyc;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    // Reference state: who was granted last and what rdata should currently hold.
    int         last_ref = NREQ - 1;
    logic [7:0] rd_ref = 8'h00;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = d;
        req_rw[i] = rw;
        req[i] = 1'b1;
    endtask

    // kind: 0 normal completion, 1 start timeout, 2 busy timeout.
    task automatic serve(input int kind, input bit hold, input bit withdraw);
        int         e;
        int         n;
        int         en_c;
        int         bad;
        logic [6:0] a;
        logic [7:0] d;
        logic       rw;
        e  = rr_pick(req, last_ref);
        a  = req_addr[7*e +: 7];
        d  = req_wdata[8*e +: 8];
        rw = req_rw[e];
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_to_gnt_cycles", 32'(n), 32'd1);
        check("gnt", 32'(gnt), 32'(1) << e);
        check("m_addr", 32'(bus.m_addr), 32'(a));
        check("m_wdata", 32'(bus.m_wdata), 32'(d));
        check("m_rw", 32'(bus.m_rw), 32'(rw));
        @(posedge clk); #1;
        en_c = cyc;
        check("m_enable_after_gnt", 32'(bus.m_enable), 32'd1);
        bad = 0;
        n = 0;
        while (done == '0 && n < BT + ST + 20) begin
            if (bus.m_addr !== a || bus.m_wdata !== d || bus.m_rw !== rw ||
                32'(gnt) !== (32'(1) << e)) bad++;
            if (withdraw && !bus.m_ready) req[e] = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("cmd_gnt_hold", 32'(bad), 32'd0);
        check("done", 32'(done), 32'(1) << e);
        check("err", 32'(err), 32'(kind != 0));
        if (kind == 0 && rw) rd_ref = slave_rdata;
        check("rdata", 32'(rdata), 32'(rd_ref));
        check("m_enable_off", 32'(bus.m_enable), 32'd0);
        check("gnt_clear", 32'(gnt), 32'd0);
        case (kind)
            0:       check("ready_to_done", 32'(cyc - rise_cyc), 32'd2);
            1:       check("start_timeout", 32'(cyc - en_c), 32'(ST));
            default: check("busy_timeout", 32'(cyc - fall_cyc), 32'(BT + 2));
        endcase
        last_ref = e;
        if (!hold) req[e] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_ref = NREQ - 1;
        rd_ref = 8'h00;
    endtask

    initial begin
        int order_ok;
        int n;
        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_wdata = '0;
        req_rw = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_m_enable", 32'(bus.m_enable), 32'd0);
        check("rst_m_addr", 32'(bus.m_addr), 32'd0);
        check("rst_m_wdata", 32'(bus.m_wdata), 32'd0);
        check("rst_m_rw", 32'(bus.m_rw), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // Single write with a slow master.
        start_delay = 200;
        busy_delay = 2400;
        set_req(0, 7'h48, 8'hA5, 1'b0);
        serve(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_one_pulse", 32'(done), 32'd0);

        // Read from requester 2.
        start_delay = 10;
        busy_delay = 30;
        slave_rdata = 8'h3C;
        set_req(2, 7'h50, 8'h00, 1'b1);
        serve(0, 1'b0, 1'b0);

        // Master not ready in IDLE blocks any grant.
        hold_low = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_req(3, 7'h21, 8'h5A, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("blocked_gnt", 32'(gnt), 32'd0);
        hold_low = 1'b0;
        serve(0, 1'b0, 1'b0);

        // Requester 3 withdraws during BUSY; completion still reported.
        start_delay = 4;
        busy_delay = 50;
        set_req(3, 7'h33, 8'h11, 1'b1);
        slave_rdata = 8'h96;
        serve(0, 1'b0, 1'b1);

        // Start timeout: ready never falls.
        stuck = 1'b1;
        set_req(1, 7'h10, 8'h01, 1'b0);
        serve(1, 1'b0, 1'b0);
        stuck = 1'b0;

        // Busy timeout on a read: rdata must keep its previous value.
        start_delay = 5;
        busy_delay = 100000;
        slave_rdata = 8'hEE;
        set_req(0, 7'h40, 8'h00, 1'b1);
        serve(2, 1'b0, 1'b0);

        // Reset during BUSY.
        start_delay = 3;
        busy_delay = 500;
        set_req(2, 7'h55, 8'h77, 1'b0);
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (bus.m_ready !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(dbg_state), 32'(ST_BUSY));
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_m_enable", 32'(bus.m_enable), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        last_ref = NREQ - 1;
        rd_ref = 8'h00;
        start_delay = 6;
        busy_delay = 12;
        slave_rdata = 8'h42;
        set_req(1, 7'h11, 8'h22, 1'b1);
        set_req(2, 7'h12, 8'h23, 1'b0);
        serve(0, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);

        // Round-robin with all requests held from a fresh reset.
        do_reset();
        start_delay = 2;
        busy_delay = 5;
        for (int i = 0; i < NREQ; i++) set_req(i, 7'(8'h20 + i), 8'(i * 17), 1'b0);
        order_ok = 0;
        for (int k = 0; k < 5; k++) begin
            serve(0, 1'b1, 1'b0);
            if (last_ref == (k % NREQ)) order_ok++;
        end
        req = '0;
        check("rr_order_0_1_2_3_0", 32'(order_ok), 32'd5);

        // Randomized traffic against the round-robin reference.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)));
            end
            if (req == '0)
                set_req(int'($urandom_range(0, NREQ - 1)), 7'($urandom_range(0, 127)),
                        8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            start_delay = int'($urandom_range(1, 20));
            busy_delay = int'($urandom_range(1, 40));
            slave_rdata = 8'($urandom_range(0, 255));
            serve(0, 1'b0, 1'b0);
        end
        req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin scheduler that shares the single I2C master controller between NREQ on-board requesters, such as motor-driver config, current-sense readback and EEPROM. It selects one pending request, latches its address, data and direction, and drives the master's enable/ready handshake. It then returns read data and a completion or timeout status to the granted requester. It sits between the motor-board control logic and the I2C master controller, and is the only block allowed to drive the master's command inputs.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- START_TIMEOUT, 1024: clk cycles allowed for m_ready to fall after m_enable asserts.
- BUSY_TIMEOUT, 65535: clk cycles allowed for m_ready to return high once the transfer has started.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; held until that requester's done.
- req_addr  in  7*NREQ  7-bit slave address, slice i for requester i.
- req_wdata  in  8*NREQ  write byte, slice i.
- req_rw  in  NREQ  1 = read, 0 = write.
- gnt  out  NREQ  one-hot; high from latch until done.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 = timeout.
- rdata  out  8  read byte, valid with done for reads; holds its value until the next done.
- m_addr  out  7  to master addr.
- m_wdata  out  8  to master data_in.
- m_rw  out  1  to master rw.
- m_enable  out  1  to master enable.
- m_ready  in  1  from master ready.
- m_rdata  in  8  from master data_out.

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- **IDLE:**
  - Requires m_ready=1 and any req bit set.
  - Round-robin pick: search starts at (last_grant+1) mod NREQ.
  - Latch addr/wdata/rw of the winner into m_addr/m_wdata/m_rw, set gnt, go to ISSUE.
- **ISSUE:**
  - m_enable=1 and the timer counts.
  - m_ready=0: clear m_enable, reset the timer, go to BUSY.
  - Timer reaches START_TIMEOUT-1: set err=1, go to DONE.
- **BUSY:**
  - m_enable=0 and the timer counts.
  - m_ready=1: capture m_rdata into rdata when m_rw=1, err=0, go to DONE.
  - Timer reaches BUSY_TIMEOUT-1: err=1, go to DONE.
- **DONE:**
  - Pulse done[granted] for one cycle.
  - Update last_grant, clear gnt, go to IDLE.
- m_addr/m_wdata/m_rw stay stable from latch through DONE, because the master samples them on its slow clock.
- If a requester drops req after grant, its transaction still completes and its done still pulses.
- New req bits arriving during ISSUE/BUSY/DONE are evaluated at the next IDLE.
- m_ready=0 in IDLE (master still in STOP, or in reset) blocks any new grant.
- Write NACK is not reported by the master, so err reports timeouts only.

## Timing
- Reset values:
  - state=IDLE, gnt=0, done=0, err=0, rdata=8'h00, m_enable=0.
  - m_addr=0, m_wdata=0, m_rw=0, timer=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
- rst asserted mid-transfer: immediate return to reset values, with no done pulse. The master is reset by the same rst.
- Latency:
  - req to gnt: 1 clk from IDLE.
  - gnt to m_enable: 1 clk.
  - done follows the m_ready rise by 2 clk (BUSY→DONE, done registered).
- Back-to-back grants: one IDLE cycle separates DONE from the next gnt.
- Both timers are 17-bit saturating. A timeout at exactly the limit cycle wins over an m_ready edge in the same cycle.

## Structure
- Package i2c_arb_pkg:
  - State encoding for IDLE/ISSUE/BUSY/DONE.
  - Constants ADDR_W=7, DATA_W=8, TIMER_W=17.
- Sub-module rr_arbiter (NREQ): inputs req and last_grant, outputs a one-hot winner and a valid flag. It is purely combinational and instantiated once.
- The FSM, latches and timer live in i2c_master_arbiter.

## Test plan
- **Single write:** req[0]=1, addr=7'h48, wdata=8'hA5, rw=0, with a master model that drops m_ready 200 clk after enable and raises it 2400 clk later.
  - Expected: gnt[0] next clk, m_enable high until m_ready falls, done[0] one pulse, err=0.
- **Read:** req[2]=1, addr=7'h50, rw=1, model returns m_rdata=8'h3C.
  - Expected: rdata=8'h3C with done[2], m_rw=1 held stable throughout.
- **Round-robin:** req=4'b1111 held asserted.
  - Expected: grant order 0,1,2,3,0.
- **Start timeout:** m_ready stuck high after enable.
  - Expected: done with err=1 at exactly START_TIMEOUT clk after m_enable rose, m_enable=0 afterwards.
- **Reset mid-transfer:** rst pulsed during BUSY.
  - Expected: gnt=0, done=0, m_enable=0 immediately; the next req[1] is granted first after reset.
- **Request withdrawn:** req[3] dropped during BUSY.
  - Expected: transaction completes and done[3] still pulses.
